pc_sequencer: RTL

//  Parametrised program-counter sequencer for the fetch stage; replaces the bare PC register.

---
 rtl/pc_sequencer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: sequential advance on the fetch handshake, with
// redirect, trap entry, misaligned-target trapping and debug halt/resume.
module pc_sequencer #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned     ILEN_BYTES   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_req,
  input  logic            halt_req,
  input  logic            resume,
  input  logic            if_ready,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus,
  output logic            if_valid,
  output logic            misalign_err,
  output logic [XLEN-1:0] bad_target,
  output logic            halted
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] ILEN_MASK = XLEN'(ILEN_BYTES - 1);
  localparam logic [XLEN-1:0] ILEN_INC  = XLEN'(ILEN_BYTES);

  state_t          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] bad_target_q;
  logic            if_valid_q;
  logic            misalign_err_q;
  logic            halted_q;
  logic            target_misaligned_s;

  // Sequential increment wraps naturally at the top of the address space.
  assign pc_plus             = pc_q + ILEN_INC;
  assign target_misaligned_s = (redirect_pc & ILEN_MASK) != {XLEN{1'b0}};

  // Sequencer state, PC and all registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ST_BOOT;
      pc_q           <= RESET_VECTOR;
      bad_target_q   <= {XLEN{1'b0}};
      if_valid_q     <= 1'b0;
      misalign_err_q <= 1'b0;
      halted_q       <= 1'b0;
    end else begin
      misalign_err_q <= 1'b0;
      case (state_q)
        ST_BOOT: begin
          state_q    <= ST_RUN;
          if_valid_q <= 1'b1;
        end
        ST_RUN: begin
          if (trap_req) begin
            pc_q <= TRAP_VECTOR;
          end else if (redirect_valid && !target_misaligned_s) begin
            pc_q <= redirect_pc;
          end else if (redirect_valid) begin
            pc_q           <= TRAP_VECTOR;
            misalign_err_q <= 1'b1;
            bad_target_q   <= redirect_pc;
          end else if (halt_req) begin
            state_q    <= ST_HALT;
            if_valid_q <= 1'b0;
            halted_q   <= 1'b1;
          end else if (stall) begin
            pc_q <= pc_q;
          end else if (if_valid_q && if_ready) begin
            pc_q <= pc_plus;
          end else begin
            pc_q <= pc_q;
          end
        end
        ST_HALT: begin
          // A trap always leaves HALT; a redirect retargets but only resume restarts fetch.
          if (trap_req) begin
            pc_q       <= TRAP_VECTOR;
            state_q    <= ST_RUN;
            if_valid_q <= 1'b1;
            halted_q   <= 1'b0;
          end else begin
            if (redirect_valid && !target_misaligned_s) begin
              pc_q <= redirect_pc;
            end else if (redirect_valid) begin
              pc_q           <= TRAP_VECTOR;
              misalign_err_q <= 1'b1;
              bad_target_q   <= redirect_pc;
            end else begin
              pc_q <= pc_q;
            end
            if (resume) begin
              state_q    <= ST_RUN;
              if_valid_q <= 1'b1;
              halted_q   <= 1'b0;
            end else begin
              state_q <= ST_HALT;
            end
          end
        end
        default: begin
          state_q    <= ST_BOOT;
          pc_q       <= RESET_VECTOR;
          if_valid_q <= 1'b0;
          halted_q   <= 1'b0;
        end
      endcase
    end
  end

  assign pc           = pc_q;
  assign if_valid     = if_valid_q;
  assign misalign_err = misalign_err_q;
  assign bad_target   = bad_target_q;
  assign halted       = halted_q;

endmodule
